// File: rtl/szcv_flag_unit_pkg.sv
// rtl/szcv_flag_unit_pkg.sv - shared phase, condition, opcode and flag-bit definitions for the SZCV flag unit
package szcv_flag_unit_pkg;

   localparam int PH_EXEC = 0;
   localparam int PH_EVAL = 1;
   localparam int PH_PC   = 2;

   localparam logic [2:0] COND_BE  = 3'b000;
   localparam logic [2:0] COND_BLT = 3'b001;
   localparam logic [2:0] COND_BLE = 3'b010;
   localparam logic [2:0] COND_BNE = 3'b011;

   localparam logic [4:0] BR_OPC = 5'b10111;

   localparam int F_S = 3;
   localparam int F_Z = 2;
   localparam int F_C = 1;
   localparam int F_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EVAL    = 2'd1,
      ST_RESOLVE = 2'd2
   } br_state_e;

   function automatic logic is_cond_branch(input logic [15:0] instr);
      return instr[15:11] == BR_OPC;
   endfunction

endpackage

// File: rtl/szcv_cond_eval.sv
// rtl/szcv_cond_eval.sv - combinational {flags, cond} to branch-taken mapping
module szcv_cond_eval
   import szcv_flag_unit_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [2:0] cond,
   output logic       taken
);

   logic s_xor_v;
   logic unused_carry;

   assign s_xor_v      = flags[F_S] ^ flags[F_V];
   assign unused_carry = flags[F_C];

   // Reserved encodings fall to the default and are never taken.
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_BE:  taken = flags[F_Z];
         COND_BLT: taken = s_xor_v;
         COND_BLE: taken = flags[F_Z] | s_xor_v;
         COND_BNE: taken = ~flags[F_Z];
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/szcv_flag_unit.sv
// rtl/szcv_flag_unit.sv - SZCV flag register and registered conditional-branch decision
// Optional fused execute/evaluate flag bypass: SZCV_BYPASS_EN.
module szcv_flag_unit
   import szcv_flag_unit_pkg::*;
#(
   parameter int PHASES = 3
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr,
   input  logic [PHASES-1:0] phase,
   input  logic              szcv_enable,
   input  logic [3:0]        alu_szcv,
   input  logic              stall,
   output logic [3:0]        flags,
   output logic              br_valid,
   output logic              br_taken
);

   br_state_e  state_q, state_d;
   logic [3:0] flags_q;
   logic [3:0] eval_src;
   logic       dec_q, dec_d;
   logic       valid_q, valid_d;
   logic       taken_q, taken_d;
   logic       ph_exec, ph_eval, ph_pc, phase_early;
   logic       eval_taken;
   logic       unused_bits;

   assign ph_exec     = phase[PH_EXEC];
   assign ph_pc       = phase[PH_PC] & ~phase[PH_EXEC] & ~phase[PH_EVAL];
   assign phase_early = phase[PH_EXEC] | phase[PH_EVAL];
   assign unused_bits = ^{instr[7:0], phase};

`ifdef SZCV_BYPASS_EN
   assign ph_eval  = phase[PH_EVAL];
   assign eval_src = (phase[PH_EXEC] & phase[PH_EVAL] & szcv_enable) ? alu_szcv : flags_q;
`else
   // A multi-hot phase behaves as execute only.
   assign ph_eval  = phase[PH_EVAL] & ~phase[PH_EXEC];
   assign eval_src = flags_q;
`endif

   szcv_cond_eval u_cond_eval (
      .flags (eval_src),
      .cond  (instr[10:8]),
      .taken (eval_taken)
   );

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      valid_d = valid_q;
      taken_d = taken_q;
      if (!stall) begin
         case (state_q)
            ST_IDLE: begin
               if (ph_eval && is_cond_branch(instr)) begin
                  state_d = ST_EVAL;
                  dec_d   = eval_taken;
               end
            end
            ST_EVAL: begin
               if (ph_pc) begin
                  state_d = ST_RESOLVE;
                  valid_d = 1'b1;
                  taken_d = dec_q;
               end else if (phase_early) begin
                  state_d = ST_IDLE;
               end
            end
            ST_RESOLVE: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         flags_q <= 4'b0000;
         dec_q   <= 1'b0;
         valid_q <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         valid_q <= valid_d;
         taken_q <= taken_d;
         if (!stall && ph_exec && szcv_enable) begin
            flags_q <= alu_szcv;
         end
      end
   end

   assign flags    = flags_q;
   assign br_valid = valid_q;
   assign br_taken = taken_q;

endmodule

// File: tb/tb_szcv_flag_unit.sv
// tb/tb_szcv_flag_unit.sv - directed self-checking bench for szcv_flag_unit
module tb_szcv_flag_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic [2:0]  phase = 3'b000;
   logic        szcv_enable = 1'b0;
   logic [3:0]  alu_szcv = 4'b0000;
   logic        stall = 1'b0;
   logic [3:0]  flags;
   logic        br_valid;
   logic        br_taken;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   logic [3:0] m_flags;
   logic       m_valid;
   logic       m_taken;
   int         m_pend;

   szcv_flag_unit #(.PHASES(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .phase       (phase),
      .szcv_enable (szcv_enable),
      .alu_szcv    (alu_szcv),
      .stall       (stall),
      .flags       (flags),
      .br_valid    (br_valid),
      .br_taken    (br_taken)
   );

   always #5 clk = ~clk;

   function automatic int decide(input logic [3:0] f, input logic [15:0] ins);
      int s, z, v;
      s = f[3];
      z = f[2];
      v = f[0];
      case (ins[10:8])
         3'd0: return z;
         3'd1: return (s != v) ? 1 : 0;
         3'd2: return (z == 1 || s != v) ? 1 : 0;
         3'd3: return 1 - z;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_flags", flags, m_flags);
         chk("model_br_valid", {3'b0, br_valid}, {3'b0, m_valid});
         if (m_valid) chk("model_br_taken", {3'b0, br_taken}, {3'b0, m_taken});
      end
   end

   // Drive one cycle, then advance the reference model across the edge.
   task automatic step(input logic [2:0] ph, input logic [15:0] ins, input logic en,
                       input logic [3:0] alu, input logic stl, input logic r);
      logic [3:0] f_before;
      bit is_br, eval_now;
      phase = ph; instr = ins; szcv_enable = en; alu_szcv = alu; stall = stl; rst = r;
      @(posedge clk);
      f_before = m_flags;
      is_br = (ins[15:11] == 5'b10111);
`ifdef SZCV_BYPASS_EN
      eval_now = ph[1];
      if (ph[0] && ph[1] && en) f_before = alu;
`else
      eval_now = ph[1] && !ph[0];
`endif
      if (r) begin
         m_flags = 4'b0000; m_valid = 1'b0; m_taken = 1'b0; m_pend = -1;
      end else if (!stl) begin
         if (m_valid) begin
            m_valid = 1'b0;
         end else if (m_pend >= 0) begin
            if (ph == 3'b100) begin
               m_valid = 1'b1;
               m_taken = (m_pend == 1);
               m_pend  = -1;
            end else if (ph[0] || ph[1]) begin
               m_pend = -1;
            end
         end else if (eval_now && is_br) begin
            m_pend = decide(f_before, ins);
         end
         if (ph[0] && en) m_flags = alu;
      end
      @(negedge clk);
   endtask

   task automatic load(input logic [3:0] f);
      step(3'b001, 16'h0000, 1'b1, f, 1'b0, 1'b0);
   endtask

   task automatic branch(input logic [15:0] ins);
      step(3'b010, ins, 1'b0, 4'b0000, 1'b0, 1'b0);
      step(3'b100, ins, 1'b0, 4'b0000, 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(3'b000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
   endtask

   initial begin
      m_flags = 4'b0000; m_valid = 1'b0; m_taken = 1'b0; m_pend = -1;
      @(negedge clk);
      step(3'b000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      check_en = 1'b1;
      chk("reset_flags", flags, 4'b0000);
      chk("reset_valid", {3'b0, br_valid}, 4'b0000);

      load(4'b0100);
      chk("flag_load", flags, 4'b0100);
      step(3'b010, 16'hC050, 1'b1, 4'b1111, 1'b0, 1'b0);
      chk("flag_hold_ph1", flags, 4'b0100);
      idle();

      branch(16'hB800);
      chk("be_valid", {3'b0, br_valid}, 4'b0001);
      chk("be_taken", {3'b0, br_taken}, 4'b0001);
      idle();
      chk("be_pulse_end", {3'b0, br_valid}, 4'b0000);

      load(4'b0000);
      branch(16'hB800);
      chk("be_not_taken", {3'b0, br_taken}, 4'b0000);
      idle();

      load(4'b1000);
      branch(16'hB900);
      chk("blt_taken", {3'b0, br_taken}, 4'b0001);
      idle();
      load(4'b1001);
      branch(16'hB900);
      chk("blt_not_taken", {3'b0, br_taken}, 4'b0000);
      idle();
      branch(16'hBA00);
      chk("ble_not_taken", {3'b0, br_taken}, 4'b0000);
      idle();
      load(4'b0000);
      branch(16'hBB00);
      chk("bne_taken", {3'b0, br_taken}, 4'b0001);
      idle();

      load(4'b0100);
      branch(16'hB800);
      for (int i = 0; i < 3; i++) begin
         step(3'b001, 16'h0000, 1'b1, 4'b1111, 1'b1, 1'b0);
         chk("stall_valid_held", {3'b0, br_valid}, 4'b0001);
         chk("stall_flags_held", flags, 4'b0100);
      end
      step(3'b001, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("stall_release", {3'b0, br_valid}, 4'b0000);

      branch(16'hBF00);
      chk("reserved_valid", {3'b0, br_valid}, 4'b0001);
      chk("reserved_taken", {3'b0, br_taken}, 4'b0000);
      idle();

      branch(16'hC050);
      chk("nonbranch_no_pulse", {3'b0, br_valid}, 4'b0000);
      idle();

      step(3'b010, 16'hB800, 1'b0, 4'b0000, 1'b0, 1'b0);
      step(3'b001, 16'hB800, 1'b0, 4'b0000, 1'b0, 1'b0);
      step(3'b100, 16'hB800, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("malformed_no_pulse", {3'b0, br_valid}, 4'b0000);
      idle();

      step(3'b010, 16'hB800, 1'b0, 4'b0000, 1'b0, 1'b0);
      step(3'b000, 16'hB800, 1'b0, 4'b0000, 1'b1, 1'b1);
      chk("midrst_flags", flags, 4'b0000);
      chk("midrst_valid", {3'b0, br_valid}, 4'b0000);
      step(3'b100, 16'hB800, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("midrst_no_pulse", {3'b0, br_valid}, 4'b0000);
      idle();

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
